// File: rtl/apu_core_arbiter.sv
// apu_core_arbiter: merges the APU request ports of NB_CORES cores onto one
// shared unit with locked round-robin arbitration. An in-order ID FIFO steers
// each unit result back to the core that issued it.
module apu_core_arbiter #(
    parameter int unsigned NB_CORES = 8,
    parameter int unsigned NARGS    = 3,
    parameter int unsigned WOP      = 6,
    parameter int unsigned NDSFLAGS = 13,
    parameter int unsigned NUSFLAGS = 7,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,

    input  logic [NB_CORES-1:0]              core_req_i,
    output logic [NB_CORES-1:0]              core_gnt_o,
    input  logic [NB_CORES*WOP-1:0]          core_op_i,
    input  logic [NB_CORES*NARGS*32-1:0]     core_operands_i,
    input  logic [NB_CORES*NDSFLAGS-1:0]     core_flags_i,
    output logic [NB_CORES-1:0]              core_rvalid_o,
    output logic [31:0]                      core_result_o,
    output logic [NUSFLAGS-1:0]              core_rflags_o,

    output logic                             unit_req_o,
    input  logic                             unit_gnt_i,
    output logic [WOP-1:0]                   unit_op_o,
    output logic [NARGS*32-1:0]              unit_operands_o,
    output logic [NDSFLAGS-1:0]              unit_flags_o,
    input  logic                             unit_rvalid_i,
    input  logic [31:0]                      unit_result_i,
    input  logic [NUSFLAGS-1:0]              unit_rflags_i,

    output logic [$clog2(DEPTH):0]           outstanding_o
);

    localparam int unsigned IDX_W  = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned OPND_W = NARGS * 32;

    // Arbitration state
    logic [IDX_W-1:0] rr_q, rr_d;
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] sel_q, sel_d;

    // ID FIFO state
    logic [IDX_W-1:0] id_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Combinational helpers
    logic [IDX_W-1:0] arb_idx;
    logic             arb_found;
    logic [31:0]      cand;
    logic [IDX_W-1:0] cand_idx;
    logic [IDX_W-1:0] sel;
    logic             fifo_full;
    logic             fifo_empty;
    logic             can_accept;
    logic             push;
    logic             pop;
    logic [IDX_W-1:0] head_id;

    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign can_accept = !fifo_full || unit_rvalid_i;
    assign unit_req_o = (|core_req_i) && can_accept;
    assign push       = unit_req_o && unit_gnt_i;
    assign pop        = unit_rvalid_i && !fifo_empty;
    assign head_id    = id_mem[rd_ptr_q];
    assign sel        = lock_q ? sel_q : arb_idx;

    assign core_result_o = unit_result_i;
    assign core_rflags_o = unit_rflags_i;
    assign outstanding_o = count_q;

    // Round-robin search: first requester at or after rr_q, wrapping upward
    always_comb begin
        arb_idx   = rr_q;
        arb_found = 1'b0;
        cand      = '0;
        cand_idx  = '0;
        for (int unsigned i = 0; i < NB_CORES; i++) begin
            cand     = (32'(rr_q) + i) % NB_CORES;
            cand_idx = IDX_W'(cand);
            if (!arb_found && core_req_i[cand_idx]) begin
                arb_idx   = cand_idx;
                arb_found = 1'b1;
            end
        end
    end

    // Payload mux toward the unit and one-hot grant back to the cores
    always_comb begin
        unit_op_o       = '0;
        unit_operands_o = '0;
        unit_flags_o    = '0;
        core_gnt_o      = '0;
        for (int unsigned k = 0; k < NB_CORES; k++) begin
            if (sel == IDX_W'(k)) begin
                unit_op_o       = core_op_i[k*WOP +: WOP];
                unit_operands_o = core_operands_i[k*OPND_W +: OPND_W];
                unit_flags_o    = core_flags_i[k*NDSFLAGS +: NDSFLAGS];
                core_gnt_o[k]   = push;
            end
        end
    end

    // Result routing to the core at the FIFO head; stray results are dropped
    always_comb begin
        core_rvalid_o = '0;
        for (int unsigned k = 0; k < NB_CORES; k++) begin
            if (pop && (head_id == IDX_W'(k))) begin
                core_rvalid_o[k] = 1'b1;
            end
        end
    end

    // Next state for pointer, lock and FIFO bookkeeping
    always_comb begin
        rr_d     = rr_q;
        lock_d   = lock_q;
        sel_d    = sel_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            lock_d = 1'b0;
            rr_d   = (sel == IDX_W'(NB_CORES - 1)) ? '0 : sel + IDX_W'(1);
        end else if (unit_req_o) begin
            // Hold the selection so the payload stays stable until granted
            lock_d = 1'b1;
            sel_d  = sel;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Arbitration and FIFO pointer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q     <= '0;
            lock_q   <= 1'b0;
            sel_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rr_q     <= rr_d;
            lock_q   <= lock_d;
            sel_q    <= sel_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ID FIFO storage: granted core index written at the tail on each transfer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                id_mem[i] <= '0;
            end
        end else if (push) begin
            id_mem[wr_ptr_q] <= sel;
        end
    end

    // Flag a result that arrives with nothing outstanding
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(unit_rvalid_i && fifo_empty))
                else $warning("apu_core_arbiter: unit result with no outstanding transfer dropped");
        end
    end

endmodule

// File: tb/tb_apu_core_arbiter.sv
// Directed testbench for apu_core_arbiter with hand-computed expectations.
module tb_apu_core_arbiter;

    localparam int unsigned NB_CORES = 8;
    localparam int unsigned NARGS    = 3;
    localparam int unsigned WOP      = 6;
    localparam int unsigned NDSFLAGS = 13;
    localparam int unsigned NUSFLAGS = 7;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned OPND_W   = NARGS * 32;

    logic                         clk_i;
    logic                         rst_ni;
    logic [NB_CORES-1:0]          core_req_i;
    logic [NB_CORES-1:0]          core_gnt_o;
    logic [NB_CORES*WOP-1:0]      core_op_i;
    logic [NB_CORES*OPND_W-1:0]   core_operands_i;
    logic [NB_CORES*NDSFLAGS-1:0] core_flags_i;
    logic [NB_CORES-1:0]          core_rvalid_o;
    logic [31:0]                  core_result_o;
    logic [NUSFLAGS-1:0]          core_rflags_o;
    logic                         unit_req_o;
    logic                         unit_gnt_i;
    logic [WOP-1:0]               unit_op_o;
    logic [OPND_W-1:0]            unit_operands_o;
    logic [NDSFLAGS-1:0]          unit_flags_o;
    logic                         unit_rvalid_i;
    logic [31:0]                  unit_result_i;
    logic [NUSFLAGS-1:0]          unit_rflags_i;
    logic [$clog2(DEPTH):0]       outstanding_o;

    int n_checks = 0;
    int n_fail   = 0;

    apu_core_arbiter #(
        .NB_CORES (NB_CORES),
        .NARGS    (NARGS),
        .WOP      (WOP),
        .NDSFLAGS (NDSFLAGS),
        .NUSFLAGS (NUSFLAGS),
        .DEPTH    (DEPTH)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .core_req_i      (core_req_i),
        .core_gnt_o      (core_gnt_o),
        .core_op_i       (core_op_i),
        .core_operands_i (core_operands_i),
        .core_flags_i    (core_flags_i),
        .core_rvalid_o   (core_rvalid_o),
        .core_result_o   (core_result_o),
        .core_rflags_o   (core_rflags_o),
        .unit_req_o      (unit_req_o),
        .unit_gnt_i      (unit_gnt_i),
        .unit_op_o       (unit_op_o),
        .unit_operands_o (unit_operands_o),
        .unit_flags_o    (unit_flags_o),
        .unit_rvalid_i   (unit_rvalid_i),
        .unit_result_i   (unit_result_i),
        .unit_rflags_i   (unit_rflags_i),
        .outstanding_o   (outstanding_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_core(input int k, input logic [WOP-1:0] op, input logic [31:0] a0,
                            input logic [31:0] a1, input logic [31:0] a2,
                            input logic [NDSFLAGS-1:0] fl);
        core_op_i[k*WOP +: WOP]               = op;
        core_operands_i[k*OPND_W +: OPND_W]   = {a2, a1, a0};
        core_flags_i[k*NDSFLAGS +: NDSFLAGS]  = fl;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp_g [4];
        logic [7:0] exp_r [4];

        rst_ni          = 1'b0;
        core_req_i      = '0;
        core_op_i       = '0;
        core_operands_i = '0;
        core_flags_i    = '0;
        unit_gnt_i      = 1'b0;
        unit_rvalid_i   = 1'b0;
        unit_result_i   = '0;
        unit_rflags_i   = '0;

        // Reset state
        #3;
        check("rst_gnt", core_gnt_o, 8'h00);
        check("rst_req", unit_req_o, 1'b0);
        check("rst_outst", outstanding_o, 3'd0);
        check("rst_rvalid", core_rvalid_o, 8'h00);
        step();
        step();
        rst_ni = 1'b1;
        step();

        // Lock: core 5 stalled; core 1 would win the round-robin but must wait
        set_core(5, 6'h25, 32'h50, 32'h51, 32'h52, 13'h155);
        set_core(1, 6'h11, 32'h10, 32'h11, 32'h12, 13'h011);
        core_req_i = 8'h20;
        unit_gnt_i = 1'b0;
        #1;
        check("lock_c0_req", unit_req_o, 1'b1);
        check("lock_c0_op", unit_op_o, 6'h25);
        check("lock_c0_gnt", core_gnt_o, 8'h00);
        step();
        core_req_i = 8'h22;
        #1;
        check("lock_c1_op", unit_op_o, 6'h25);
        check("lock_c1_opnd", unit_operands_o, {32'h52, 32'h51, 32'h50});
        check("lock_c1_gnt", core_gnt_o, 8'h00);
        step();
        #1;
        check("lock_c2_op", unit_op_o, 6'h25);
        check("lock_c2_flags", unit_flags_o, 13'h155);
        step();
        unit_gnt_i = 1'b1;
        #1;
        check("lock_c3_gnt", core_gnt_o, 8'h20);
        step();
        core_req_i = 8'h02;
        #1;
        check("lock_c4_gnt", core_gnt_o, 8'h02);
        check("lock_c4_op", unit_op_o, 6'h11);
        step();
        core_req_i = 8'h00;
        unit_gnt_i = 1'b0;
        #1;
        check("lock_outst", outstanding_o, 3'd2);
        unit_rvalid_i = 1'b1;
        #1;
        check("lock_rv0", core_rvalid_o, 8'h20);
        step();
        #1;
        check("lock_rv1", core_rvalid_o, 8'h02);
        step();
        unit_rvalid_i = 1'b0;

        // Single request from core 2, result three cycles later
        set_core(2, 6'd5, 32'd1, 32'd2, 32'd3, 13'h0A5);
        core_req_i = 8'h04;
        unit_gnt_i = 1'b1;
        #1;
        check("single_gnt", core_gnt_o, 8'h04);
        check("single_req", unit_req_o, 1'b1);
        check("single_op", unit_op_o, 6'd5);
        check("single_opnd", unit_operands_o, {32'd3, 32'd2, 32'd1});
        check("single_flags", unit_flags_o, 13'h0A5);
        step();
        core_req_i = 8'h00;
        unit_gnt_i = 1'b0;
        #1;
        check("single_outst", outstanding_o, 3'd1);
        check("single_norv", core_rvalid_o, 8'h00);
        step();
        step();
        unit_rvalid_i = 1'b1;
        unit_result_i = 32'hCAFE;
        unit_rflags_i = 7'h15;
        #1;
        check("single_rv", core_rvalid_o, 8'h04);
        check("single_res", core_result_o, 32'hCAFE);
        check("single_rfl", core_rflags_o, 7'h15);
        step();
        unit_rvalid_i = 1'b0;
        #1;
        check("single_outst0", outstanding_o, 3'd0);

        // Round robin between cores 0 and 3 (pointer sits at 3), filling the FIFO
        set_core(0, 6'h01, 32'hA0, 32'hA1, 32'hA2, 13'h001);
        set_core(3, 6'h03, 32'hB0, 32'hB1, 32'hB2, 13'h003);
        exp_g[0] = 8'h08; exp_g[1] = 8'h01; exp_g[2] = 8'h08; exp_g[3] = 8'h01;
        core_req_i = 8'h09;
        unit_gnt_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr_gnt%0d", i), core_gnt_o, exp_g[i]);
            step();
        end
        #1;
        check("bp_outst_full", outstanding_o, 3'd4);
        check("bp_req_blocked", unit_req_o, 1'b0);
        check("bp_gnt_blocked", core_gnt_o, 8'h00);

        // Full FIFO with a simultaneous result: one in, one out
        core_req_i    = 8'h02;
        unit_rvalid_i = 1'b1;
        unit_result_i = 32'h1234;
        #1;
        check("bp_req_swap", unit_req_o, 1'b1);
        check("bp_gnt_swap", core_gnt_o, 8'h02);
        check("bp_rv_swap", core_rvalid_o, 8'h08);
        step();
        core_req_i    = 8'h00;
        unit_gnt_i    = 1'b0;
        unit_rvalid_i = 1'b0;
        #1;
        check("bp_outst_stay", outstanding_o, 3'd4);
        exp_r[0] = 8'h01; exp_r[1] = 8'h08; exp_r[2] = 8'h01; exp_r[3] = 8'h02;
        unit_rvalid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("drain_rv%0d", i), core_rvalid_o, exp_r[i]);
            step();
        end
        unit_rvalid_i = 1'b0;
        #1;
        check("drain_outst", outstanding_o, 3'd0);

        // Stray result with nothing outstanding is dropped
        unit_rvalid_i = 1'b1;
        unit_result_i = 32'hDEAD;
        #1;
        check("perr_rv", core_rvalid_o, 8'h00);
        step();
        unit_rvalid_i = 1'b0;
        #1;
        check("perr_outst", outstanding_o, 3'd0);

        // Reset with three results outstanding
        core_req_i = 8'h01;
        unit_gnt_i = 1'b1;
        step();
        step();
        step();
        core_req_i = 8'h00;
        unit_gnt_i = 1'b0;
        #1;
        check("mrst_outst3", outstanding_o, 3'd3);
        #2;
        rst_ni = 1'b0;
        #1;
        check("mrst_outst0", outstanding_o, 3'd0);
        check("mrst_gnt", core_gnt_o, 8'h00);
        check("mrst_req", unit_req_o, 1'b0);
        check("mrst_rv", core_rvalid_o, 8'h00);
        step();
        rst_ni = 1'b1;
        step();
        unit_rvalid_i = 1'b1;
        #1;
        check("mrst_stale_rv", core_rvalid_o, 8'h00);
        step();
        unit_rvalid_i = 1'b0;
        core_req_i    = 8'h01;
        unit_gnt_i    = 1'b1;
        #1;
        check("mrst_new_gnt", core_gnt_o, 8'h01);
        step();
        core_req_i = 8'h00;
        unit_gnt_i = 1'b0;
        #1;
        check("mrst_new_outst", outstanding_o, 3'd1);
        unit_rvalid_i = 1'b1;
        unit_result_i = 32'h0BEE;
        #1;
        check("mrst_new_rv", core_rvalid_o, 8'h01);
        step();
        unit_rvalid_i = 1'b0;
        #1;
        check("mrst_final_outst", outstanding_o, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
